// File: rtl/ahb_dump_pkg.sv
// Shared types and register map for the AHB dump-slave sequencer.
package ahb_dump_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [3:0] {
        StIdle,
        StName,
        StLen,
        StOpen,
        StStream,
        StClose,
        StStop,
        StDone,
        StErr
    } dump_state_e;

    localparam logic [31:0] OFS_PUTC  = 32'h0000_0000;
    localparam logic [31:0] OFS_STOP  = 32'h0000_0004;
    localparam logic [31:0] OFS_HEX   = 32'h0000_0008;
    localparam logic [31:0] OFS_LEN   = 32'h0000_000C;
    localparam logic [31:0] OFS_OPEN  = 32'h0000_0010;
    localparam logic [31:0] OFS_DATA  = 32'h0000_0014;
    localparam logic [31:0] OFS_CLOSE = 32'h0000_0018;
    localparam logic [31:0] OFS_NAME  = 32'h0000_1000;

    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic [3:0] HPROT_DATA = 4'b0011;

endpackage

// File: rtl/ahb_dump_wr_pipe.sv
// Single-write AHB-Lite master pipeline: registered address phase, registered data phase,
// HREADY stall and cancellation of the pipelined address on an error response.
module ahb_dump_wr_pipe
    import ahb_dump_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        req_ready_o,
    output logic        wr_err_o,
    output logic        drain_o,
    output logic [31:0] haddr_o,
    output logic [1:0]  htrans_o,
    output logic        hwrite_o,
    output logic [31:0] hwdata_o,
    input  logic        hready_i,
    input  logic        hresp_i
);

    logic [31:0] haddr_q, haddr_d;
    htrans_e     htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] addr_wdata_q, addr_wdata_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        data_vld_q, data_vld_d;
    logic        err_cyc;

    assign err_cyc     = data_vld_q && hresp_i;
    assign req_ready_o = hready_i && !err_cyc;
    assign wr_err_o    = err_cyc && !hready_i;
    // Last outstanding write finishes this cycle with nothing queued behind it.
    assign drain_o     = data_vld_q && hready_i && !hresp_i && (htrans_q == HtransIdle);

    always_comb begin
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        addr_wdata_d = addr_wdata_q;
        hwdata_d     = hwdata_q;
        data_vld_d   = data_vld_q;
        if (wr_err_o) begin
            htrans_d = HtransIdle;
            hwrite_d = 1'b0;
        end else if (hready_i) begin
            data_vld_d = (htrans_q == HtransNonseq);
            if (htrans_q == HtransNonseq) begin
                hwdata_d = addr_wdata_q;
            end
            if (req_valid_i && req_ready_o) begin
                htrans_d     = HtransNonseq;
                hwrite_d     = 1'b1;
                haddr_d      = req_addr_i;
                addr_wdata_d = req_data_i;
            end else begin
                htrans_d = HtransIdle;
                hwrite_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            haddr_q      <= '0;
            htrans_q     <= HtransIdle;
            hwrite_q     <= 1'b0;
            addr_wdata_q <= '0;
            hwdata_q     <= '0;
            data_vld_q   <= 1'b0;
        end else begin
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            addr_wdata_q <= addr_wdata_d;
            hwdata_q     <= hwdata_d;
            data_vld_q   <= data_vld_d;
        end
    end

    assign haddr_o  = haddr_q;
    assign htrans_o = htrans_q;
    assign hwrite_o = hwrite_q;
    assign hwdata_o = hwdata_q;

endmodule

// File: rtl/ahb_dump_sequencer.sv
// Sequences the dump slave's file protocol (name, length, open, stream, close) over AHB-Lite.
// Define AHB_DUMP_STOP_EN to issue a simulation-stop write after the close.
module ahb_dump_sequencer
    import ahb_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned NAME_WORDS = 4,
    parameter int unsigned CNT_W      = 24
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    start,
    input  logic [32*NAME_WORDS-1:0] fname,
    input  logic [31:0]             fname_len,
    input  logic                    abort,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    input  logic                    s_last,
    output logic [31:0]             HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [3:0]              HPROT,
    output logic [31:0]             HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNT_W-1:0]        word_cnt
);

    localparam int unsigned IDX_W = (NAME_WORDS > 1) ? $clog2(NAME_WORDS) : 1;
    localparam int unsigned FN_W  = 32 * NAME_WORDS;

    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FN_W-1:0]  fname_q, fname_d;
    logic [31:0]      len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             issued_q, issued_d;
    logic             err_q, err_d;

    logic        req_valid, req_ready, wr_err, drain, s_rdy;
    logic [31:0] req_addr, req_data;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fname_d   = fname_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        issued_d  = issued_q;
        err_d     = err_q;
        req_valid = 1'b0;
        req_addr  = BASE_ADDR;
        req_data  = '0;
        s_rdy     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StName;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    fname_d  = fname;
                    len_d    = fname_len;
                    idx_d    = '0;
                    abort_d  = 1'b0;
                    issued_d = 1'b0;
                end
            end
            StName: begin
                req_valid = 1'b1;
                req_addr  = BASE_ADDR + OFS_NAME + {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                req_data  = fname_q[FN_W-1 -: 32];
                if (abort) abort_d = 1'b1;
                if (req_ready) begin
                    fname_d = fname_q << 32;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NAME_WORDS - 1)) state_d = StLen;
                end
            end
            StLen: begin
                req_valid = 1'b1;
                req_addr  = BASE_ADDR + OFS_LEN;
                req_data  = len_q;
                if (abort) abort_d = 1'b1;
                if (req_ready) state_d = StOpen;
            end
            StOpen: begin
                req_valid = 1'b1;
                req_addr  = BASE_ADDR + OFS_OPEN;
                if (abort) abort_d = 1'b1;
                if (req_ready) state_d = (abort_q || abort) ? StClose : StStream;
            end
            StStream: begin
                // abort masks s_ready combinationally so a simultaneous last word is refused
                s_rdy = req_ready && !abort;
                if (abort) begin
                    state_d = StClose;
                end else if (s_valid && s_rdy) begin
                    req_valid = 1'b1;
                    req_addr  = BASE_ADDR + OFS_DATA;
                    req_data  = s_data;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    if (s_last) state_d = StClose;
                end
            end
            StClose: begin
                if (!issued_q) begin
                    req_valid = 1'b1;
                    req_addr  = BASE_ADDR + OFS_CLOSE;
                    if (req_ready) issued_d = 1'b1;
                end else if (drain) begin
                    issued_d = 1'b0;
`ifdef AHB_DUMP_STOP_EN
                    state_d  = StStop;
`else
                    state_d  = StDone;
`endif
                end
            end
            StStop: begin
                if (!issued_q) begin
                    req_valid = 1'b1;
                    req_addr  = BASE_ADDR + OFS_STOP;
                    if (req_ready) issued_d = 1'b1;
                end else if (drain) begin
                    issued_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (wr_err && (state_q inside {StName, StLen, StOpen, StStream, StClose, StStop})) begin
            state_d   = StErr;
            err_d     = 1'b1;
            issued_d  = 1'b0;
            req_valid = 1'b0;
            s_rdy     = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            fname_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            issued_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fname_q  <= fname_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    ahb_dump_wr_pipe u_wr_pipe (
        .clk_i       (HCLK),
        .rst_ni      (HRESETn),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .wr_err_o    (wr_err),
        .drain_o     (drain),
        .haddr_o     (HADDR),
        .htrans_o    (HTRANS),
        .hwrite_o    (HWRITE),
        .hwdata_o    (HWDATA),
        .hready_i    (HREADY),
        .hresp_i     (HRESP)
    );

    assign HSIZE    = HSIZE_WORD;
    assign HPROT    = HPROT_DATA;
    assign s_ready  = s_rdy;
    assign busy     = state_q inside {StName, StLen, StOpen, StStream, StClose, StStop};
    assign done     = (state_q == StDone);
    assign err      = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_ahb_dump_sequencer.sv
// Directed bench for ahb_dump_sequencer with a logging AHB slave model.
module tb_ahb_dump_sequencer;

    localparam logic [31:0] A_NAME  = 32'h4000_1000;
    localparam logic [31:0] A_LEN   = 32'h4000_000C;
    localparam logic [31:0] A_OPEN  = 32'h4000_0010;
    localparam logic [31:0] A_DATA  = 32'h4000_0014;
    localparam logic [31:0] A_CLOSE = 32'h4000_0018;
    localparam logic [31:0] A_STOP  = 32'h4000_0004;
    localparam logic [127:0] FNAME  = {32'h6F75742E, 32'h70636D00, 32'h0, 32'h0};
`ifdef AHB_DUMP_STOP_EN
    localparam int EXP_N = 11;
`else
    localparam int EXP_N = 10;
`endif

    logic HCLK = 0, HRESETn = 0, start = 0, abort = 0, s_valid = 0, s_last = 0;
    logic HREADY = 1, HRESP = 0;
    logic [127:0] fname = '0;
    logic [31:0] fname_len = '0, s_data = '0;
    logic s_ready, HWRITE, busy, done, err;
    logic [31:0] HADDR, HWDATA;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE;
    logic [3:0] HPROT;
    logic [23:0] word_cnt;

    int checks = 0, failures = 0;
    logic [31:0] log_addr[$], log_data[$];
    int log_acyc[$], log_dcyc[$];
    int cyc = 0, done_cnt = 0, n_data_addr = 0, pend_cyc = 0;
    logic pend_vld = 0;
    logic [31:0] pend_addr = '0;

    always #5 HCLK = ~HCLK;

    ahb_dump_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .fname(fname), .fname_len(fname_len),
        .abort(abort), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .busy(busy), .done(done), .err(err),
        .word_cnt(word_cnt)
    );

    // Slave model: logs completed writes with the cycle of their address and data phases.
    initial forever begin
        @(negedge HCLK);
        cyc++;
        if (!HRESETn) begin
            pend_vld = 0;
        end else begin
            if (done) done_cnt++;
            if (HREADY) begin
                if (pend_vld && !HRESP) begin
                    log_addr.push_back(pend_addr);
                    log_data.push_back(HWDATA);
                    log_acyc.push_back(pend_cyc);
                    log_dcyc.push_back(cyc);
                end
                pend_vld  = (HTRANS == 2'b10) && HWRITE;
                pend_addr = HADDR;
                pend_cyc  = cyc;
                if (pend_vld && HADDR == A_DATA) n_data_addr++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_acyc.delete(); log_dcyc.delete();
        done_cnt = 0;
        n_data_addr = 0;
    endtask

    task automatic do_start(input logic [31:0] len);
        fname = FNAME;
        fname_len = len;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        bit ok = 0;
        s_valid = 1; s_data = d; s_last = last;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (s_ready) begin
                ok = 1;
                @(posedge HCLK); #1;
                break;
            end
            @(posedge HCLK); #1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL send_word timeout data=%h", d); end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK); #1;
            if (done) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL wait_done timeout got=0 exp=1"); end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        HRESETn = 0;
        repeat (2) tick();
        checks++;
        if ({HTRANS, HWRITE, HADDR, HWDATA, busy, done, err, word_cnt, s_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs htrans=%h haddr=%h busy=%b got_nonzero exp=0", HTRANS,
                     HADDR, busy);
        end
        checks++;
        if ({HSIZE, HPROT} !== {3'b010, 4'b0011}) begin
            failures++; $display("FAIL const_hsize_hprot got=%h/%h exp=2/3", HSIZE, HPROT);
        end
        HRESETn = 1;
        tick();
    endtask

    task automatic test_full_sequence();
        logic [31:0] ea[$], ed[$];
        ea = {A_NAME, A_NAME + 4, A_NAME + 8, A_NAME + 12, A_LEN, A_OPEN, A_DATA, A_DATA, A_DATA,
              A_CLOSE};
        ed = {32'h6F75742E, 32'h70636D00, 32'h0, 32'h0, 32'd7, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0};
`ifdef AHB_DUMP_STOP_EN
        ea.push_back(A_STOP); ed.push_back(32'h0);
`endif
        clear_log();
        do_start(32'd7);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
        send_word(32'hA0, 0);
        send_word(32'hA1, 0);
        send_word(32'hA2, 1);
        s_valid = 0; s_last = 0;
        wait_done();
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
        checks++;
        if (word_cnt !== 24'd3) begin failures++; $display("FAIL full_word_cnt got=%0d exp=3", word_cnt); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_end got=%b exp=0", busy); end
        checks++;
        if (log_addr.size() !== EXP_N) begin
            failures++; $display("FAIL full_nwrites got=%0d exp=%0d", log_addr.size(), EXP_N);
        end else begin
            for (int i = 0; i < EXP_N; i++) begin
                checks++;
                if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL full_write%0d got=%h:%h exp=%h:%h", i, log_addr[i], log_data[i],
                             ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        do_start(32'd8);
        for (int i = 0; i < 8; i++) send_word(32'h1000_0000 + i, (i == 7));
        s_valid = 0; s_last = 0;
        wait_done();
        checks++;
        if (log_addr.size() !== EXP_N + 5) begin
            failures++; $display("FAIL b2b_nwrites got=%0d exp=%0d", log_addr.size(), EXP_N + 5);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[6+i] !== A_DATA || log_data[6+i] !== 32'h1000_0000 + i ||
                    log_dcyc[6+i] !== log_acyc[6+i] + 1 ||
                    (i > 0 && log_acyc[6+i] !== log_acyc[5+i] + 1)) begin
                    failures++;
                    $display("FAIL b2b_word%0d got=%h:%h acyc=%0d dcyc=%0d exp=%h:%h", i,
                             log_addr[6+i], log_data[6+i], log_acyc[6+i], log_dcyc[6+i], A_DATA,
                             32'h1000_0000 + i);
                end
            end
            checks++;
            if (log_addr[14] !== A_CLOSE) begin
                failures++; $display("FAIL b2b_close got=%h exp=%h", log_addr[14], A_CLOSE);
            end
        end
        checks++;
        if (word_cnt !== 24'd8) begin failures++; $display("FAIL b2b_word_cnt got=%0d exp=8", word_cnt); end
    endtask

    task automatic test_stall();
        clear_log();
        do_start(32'd3);
        fork
            begin
                logic [31:0] sa, sd;
                logic [1:0] st;
                for (int i = 0; i < 300; i++) begin
                    @(negedge HCLK); #1;
                    if (n_data_addr == 2) break;
                end
                @(posedge HCLK); #1;
                HREADY = 0;
                #2;
                sa = HADDR; sd = HWDATA; st = HTRANS;
                checks++;
                if (HWDATA !== 32'hB1 || s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_c1 hwdata=%h s_ready=%b exp=000000b1/0", HWDATA, s_ready);
                end
                @(posedge HCLK); #3;
                checks++;
                if (HADDR !== sa || HWDATA !== sd || HTRANS !== st || s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_c2 got=%h:%h:%h:%b exp=%h:%h:%h:0", HADDR, HWDATA, HTRANS,
                             s_ready, sa, sd, st);
                end
                @(posedge HCLK); #1;
                HREADY = 1;
            end
            begin
                send_word(32'hB0, 0);
                send_word(32'hB1, 0);
                send_word(32'hB2, 1);
                s_valid = 0; s_last = 0;
            end
        join
        wait_done();
        checks++;
        if (log_addr.size() !== EXP_N) begin
            failures++; $display("FAIL stall_nwrites got=%0d exp=%0d", log_addr.size(), EXP_N);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_addr[6+i] !== A_DATA || log_data[6+i] !== 32'hB0 + i) begin
                    failures++;
                    $display("FAIL stall_word%0d got=%h:%h exp=%h:%h", i, log_addr[6+i],
                             log_data[6+i], A_DATA, 32'hB0 + i);
                end
            end
        end
    endtask

    task automatic test_abort();
        int n14 = 0;
        clear_log();
        do_start(32'd5);
        for (int i = 0; i < 5; i++) send_word(32'hC0 + i, 0);
        s_data = 32'hCF; s_last = 1; abort = 1;
        #2;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL abort_s_ready got=%b exp=0", s_ready); end
        @(posedge HCLK); #1;
        abort = 0; s_valid = 0; s_last = 0;
        wait_done();
        checks++;
        if (word_cnt !== 24'd5) begin failures++; $display("FAIL abort_word_cnt got=%0d exp=5", word_cnt); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL abort_done got=%0d exp=1", done_cnt); end
        foreach (log_addr[i]) if (log_addr[i] == A_DATA) n14++;
        checks++;
        if (n14 !== 5) begin failures++; $display("FAIL abort_ndata got=%0d exp=5", n14); end
        checks++;
        if (log_addr.size() !== EXP_N + 2 || log_addr[11] !== A_CLOSE) begin
            failures++; $display("FAIL abort_close nwrites=%0d exp=%0d", log_addr.size(), EXP_N + 2);
        end
    endtask

    task automatic test_error();
        int bad = 0;
        clear_log();
        s_valid = 1; s_data = 32'hE0; s_last = 0;
        do_start(32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK); #1;
            if (pend_vld && pend_addr == A_OPEN) break;
        end
        @(posedge HCLK); #1;
        HREADY = 0; HRESP = 1;
        @(posedge HCLK); #1;
        HREADY = 1;
        #2;
        checks++;
        if (HTRANS !== 2'b00 || err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_cycle2 htrans=%h err=%b busy=%b exp=0/1/0", HTRANS, err, busy);
        end
        @(posedge HCLK); #1;
        HRESP = 0;
        repeat (5) tick();
        s_valid = 0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL err_sticky err=%b busy=%b exp=1/0", err, busy);
        end
        foreach (log_addr[i]) if (log_addr[i] == A_DATA || log_addr[i] == A_CLOSE) bad++;
        checks++;
        if (bad !== 0 || done_cnt !== 0) begin
            failures++; $display("FAIL err_no_close got=%0d/%0d exp=0/0", bad, done_cnt);
        end
        do_start(32'd1);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
        send_word(32'hE1, 1);
        s_valid = 0; s_last = 0;
        wait_done();
    endtask

    task automatic test_reset_mid_stream();
        clear_log();
        do_start(32'd7);
        send_word(32'hD0, 0);
        send_word(32'hD1, 0);
        HRESETn = 0;
        #1;
        checks++;
        if ({HTRANS, HWRITE, HADDR, HWDATA, busy, done, err, word_cnt, s_ready} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs htrans=%h haddr=%h busy=%b cnt=%0d exp=0", HTRANS, HADDR,
                     busy, word_cnt);
        end
        s_valid = 0;
        tick();
        HRESETn = 1;
        tick();
        clear_log();
        do_start(32'd7);
        send_word(32'hA0, 0);
        send_word(32'hA1, 0);
        send_word(32'hA2, 1);
        s_valid = 0; s_last = 0;
        wait_done();
        checks++;
        if (log_addr.size() !== EXP_N || done_cnt !== 1) begin
            failures++;
            $display("FAIL midrst_rerun nwrites=%0d done=%0d exp=%0d/1", log_addr.size(), done_cnt,
                     EXP_N);
        end else begin
            checks++;
`ifdef AHB_DUMP_STOP_EN
            if (log_addr[0] !== A_NAME || log_addr[9] !== A_CLOSE || log_addr[10] !== A_STOP) begin
`else
            if (log_addr[0] !== A_NAME || log_addr[9] !== A_CLOSE) begin
`endif
                failures++;
                $display("FAIL midrst_seq first=%h last=%h exp=%h", log_addr[0],
                         log_addr[EXP_N-1], A_NAME);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_back_to_back();
        test_stall();
        test_abort();
        test_error();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_dump_sequencer.md
Name: ahb_dump_sequencer

Overview:
AHB-Lite single-master controller for the team's simulation console/file-dump slave (BASE_ADDR map).
- Sequences the slave's file protocol for a requester: load filename, set length, open, stream 32-bit words, close.
- Sits between a producer (decoder PCM/debug tap) and the AHB interconnect.
- Replaces hand-written CPU firmware loops for dumping output files.

Parameters:
BASE_ADDR, 32'h4000_0000, base of dump slave (regs at +0x00..+0x18, name buffer at +0x1000)
NAME_WORDS, 4, filename words written (4 bytes each, MSB byte first)
CNT_W, 24, width of streamed-word counter

Ports:
HCLK  in  1  clock
HRESETn  in  1  async active-low reset
start  in  1  pulse; begins a dump when idle
fname  in  32*NAME_WORDS  filename, byte 0 in MSBs, NUL-padded
fname_len  in  32  value written to length register
abort  in  1  pulse; ends stream early, file still closed
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted
s_data  in  32  stream word
s_last  in  1  final stream word
HADDR  out  32  AHB address
HTRANS  out  2  IDLE(00)/NONSEQ(10) only
HWRITE  out  1  always 1 on NONSEQ, 0 when IDLE
HSIZE  out  3  constant 3'b010
HPROT  out  4  constant 4'b0011
HWDATA  out  32  write data
HREADY  in  1  transfer ready
HRESP  in  1  error response
busy  out  1  high from start accept until DONE/ERR
done  out  1  one-cycle pulse on successful close
err  out  1  sticky; cleared on next accepted start
word_cnt  out  CNT_W  words streamed in current dump

Behaviour:
- Reset (async, HRESETn=0): all outputs 0; HTRANS=IDLE; state IDLE.
- AHB: address phase accepted at HCLK edge with HTRANS=NONSEQ and HREADY=1. HWDATA is driven in the next cycle and held until HREADY=1. Next address phase may overlap the current data phase. All AHB outputs are registered.
- FSM states:
  - IDLE: start ignored while busy; start=1 -> NAME, busy=1, err=0, word_cnt=0, fname latched.
  - NAME: NAME_WORDS writes to BASE+0x1000+4*i, data fname[top-32*i -:32], i ascending -> LEN.
  - LEN: one write BASE+0x0C, data fname_len -> OPEN.
  - OPEN: one write BASE+0x10, data 0 -> STREAM.
  - STREAM: each s_valid&&s_ready yields a write to BASE+0x14 with s_data. word_cnt +1 per accepted word; saturates at all-ones.
    - Max throughput 1 word/cycle. Zero wait states: accepted word appears as address phase next cycle and on HWDATA the cycle after.
    - s_ready=0 while an address phase is stalled (HREADY=0) and in all other states.
    - Accepted word with s_last=1 -> CLOSE after its address phase.
  - CLOSE: write BASE+0x14 stops; one write BASE+0x18, data 0 -> DONE once its data phase completes.
  - DONE: done=1 one cycle, busy=0 -> IDLE.
- abort:
  - In STREAM: s_ready drops the same cycle; already-accepted words complete; -> CLOSE.
  - In NAME/LEN/OPEN: latched, and STREAM is skipped (OPEN -> CLOSE).
  - Ignored in IDLE/CLOSE/DONE.
- abort and s_valid&&s_last in the same cycle: abort wins; that word is not accepted.
- HRESP=1 (first error cycle, HREADY=0): drive HTRANS=IDLE next cycle, cancelling any pipelined address -> ERR. err=1, busy=0, no close issued -> IDLE.
- Reset mid-dump: immediate return to IDLE. The file left open is the slave's concern.

Optional Feature:
AHB_DUMP_STOP_EN:
- Defined: after CLOSE completes, one extra write BASE+0x04, data 0 (simulation stop), then DONE.
- Undefined: CLOSE goes directly to DONE; +0x04 is never addressed.

Decomposition:
- Package ahb_dump_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - dump_state_e
  - register offsets OFS_PUTC=0x00, OFS_STOP=0x04, OFS_HEX=0x08, OFS_LEN=0x0C, OFS_OPEN=0x10, OFS_DATA=0x14, OFS_CLOSE=0x18, OFS_NAME=0x1000
  - HSIZE_WORD, HPROT_DATA constants
- One natural sub-module: ahb_dump_wr_pipe, the single-write AHB-Lite master pipeline (addr/data phase registers, HREADY stall, error cancel). The FSM issues write requests into it.

Test Plan:
- start, fname="out.pcm" NUL-padded, fname_len=7, 3 words (last on 3rd), HREADY=1 -> exactly: 4 writes 0x40001000..0x4000100C, 0x4000000C=7, 0x40000010, 0x40000014 ×3 with matching data, 0x40000018; done pulses once; word_cnt=3.
- Streaming with s_valid held high, 8 words, zero wait -> 8 back-to-back NONSEQ cycles; HWDATA lags HADDR by exactly 1 cycle.
- HREADY=0 for 2 cycles during the 2nd data write -> HWDATA/HADDR held stable; s_ready=0 while stalled; no word lost or duplicated.
- abort after 5 words, s_valid still high -> s_ready drops the same cycle; close write follows; word_cnt=5; done=1.
- HRESP two-cycle error on the OPEN write -> next HTRANS=IDLE; no 0x14/0x18 writes; err=1, busy=0; next start clears err.
- HRESETn asserted mid-STREAM -> all outputs 0 immediately; a fresh start runs the full sequence again. With AHB_DUMP_STOP_EN, a 0x40000004 write follows the close.
